// File: rtl/heap_cell_fetch.sv
// Heap-cell read sequencer: reads a cell's word(s) from synchronous heap RAM,
// decodes the type tag and returns number/cons/nil data with the caller's continuation.
module heap_cell_fetch #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int TAG_W       = 3,
  parameter int CONT_W      = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [CONT_W-1:0]         req_cont,
  output logic                      mem_re,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [TAG_W-1:0]          resp_tag,
  output logic [DATA_W-TAG_W-1:0]   resp_value,
  output logic [ADDR_W-1:0]         resp_car,
  output logic [ADDR_W-1:0]         resp_cdr,
  output logic                      resp_nil,
  output logic                      resp_err,
  output logic [1:0]                resp_err_code,
  output logic [CONT_W-1:0]         resp_cont
);

  localparam int PAY_W = DATA_W - TAG_W;
  localparam logic [TAG_W-1:0]  TYPE_NUMBER = TAG_W'(0);
  localparam logic [TAG_W-1:0]  TYPE_CONS   = TAG_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_MAX    = '1;
  localparam logic [2:0]        LAT_LAST    = 3'(MEM_LATENCY - 1);
  localparam logic [1:0]        ERR_TAG     = 2'd1;
  localparam logic [1:0]        ERR_BOUNDS  = 2'd2;

  typedef enum logic [2:0] {IDLE, RD0, WAIT0, RD1, WAIT1, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CONT_W-1:0]   cont_q, cont_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [PAY_W-1:0]    value_q, value_d;
  logic [ADDR_W-1:0]   car_q, car_d;
  logic [ADDR_W-1:0]   cdr_q, cdr_d;
  logic                nil_q, nil_d;
  logic [1:0]          code_q, code_d;

  logic [TAG_W-1:0]    word_tag;
  assign word_tag = mem_rdata[DATA_W-1 -: TAG_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cont_q  <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      value_q <= '0;
      car_q   <= '0;
      cdr_q   <= '0;
      nil_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cont_q  <= cont_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      value_q <= value_d;
      car_q   <= car_d;
      cdr_q   <= cdr_d;
      nil_q   <= nil_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cont_d  = cont_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    value_d = value_q;
    car_d   = car_q;
    cdr_d   = cdr_q;
    nil_d   = nil_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          // Clear the previous response so non-applicable fields read as zero.
          addr_d  = req_addr;
          cont_d  = req_cont;
          tag_d   = '0;
          value_d = '0;
          car_d   = '0;
          cdr_d   = '0;
          code_d  = '0;
          nil_d   = (req_addr == '0);
          state_d = (req_addr == '0) ? RESP : RD0;
        end
      end
      RD0: begin
        cnt_d   = '0;
        state_d = WAIT0;
      end
      WAIT0: begin
        if (cnt_q == LAT_LAST) begin
          tag_d = word_tag;
          if (word_tag == TYPE_NUMBER) begin
            value_d = mem_rdata[PAY_W-1:0];
            state_d = RESP;
          end else if (word_tag == TYPE_CONS) begin
            car_d = mem_rdata[ADDR_W-1:0];
            // The cdr word of the top cell would wrap to address 0; refuse it.
            if (addr_q == ADDR_MAX) begin
              code_d  = ERR_BOUNDS;
              state_d = RESP;
            end else begin
              state_d = RD1;
            end
          end else begin
            code_d  = ERR_TAG;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RD1: begin
        cnt_d   = '0;
        state_d = WAIT1;
      end
      WAIT1: begin
        if (cnt_q == LAT_LAST) begin
          cdr_d   = mem_rdata[ADDR_W-1:0];
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_addr = '0;
    if (state_q == RD0) mem_addr = addr_q;
    if (state_q == RD1) mem_addr = addr_q + ADDR_W'(1);
  end

  assign req_ready     = (state_q == IDLE);
  assign mem_re        = (state_q == RD0) || (state_q == RD1);
  assign resp_valid    = (state_q == RESP);
  assign resp_tag      = tag_q;
  assign resp_value    = value_q;
  assign resp_car      = car_q;
  assign resp_cdr      = cdr_q;
  assign resp_nil      = nil_q;
  assign resp_err      = (code_q != 2'd0);
  assign resp_err_code = code_q;
  assign resp_cont     = cont_q;

endmodule

// File: tb/tb_heap_cell_fetch.sv
// Scoreboard bench for heap_cell_fetch: directed cases plus randomized requests
// against a behavioural heap model with a MEM_LATENCY-deep read pipeline.
module tb_heap_cell_fetch;
  localparam int AW = 12, DW = 16, TW = 3, CW = 4, L = 2;

  logic          clk = 0, rst_n = 0;
  logic          req_valid = 0, req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [CW-1:0] req_cont = '0;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          resp_valid, resp_ready = 1;
  logic [TW-1:0] resp_tag;
  logic [DW-TW-1:0] resp_value;
  logic [AW-1:0] resp_car, resp_cdr;
  logic          resp_nil, resp_err;
  logic [1:0]    resp_err_code;
  logic [CW-1:0] resp_cont;

  heap_cell_fetch #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .CONT_W(CW), .MEM_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_cont(req_cont), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_tag(resp_tag), .resp_value(resp_value), .resp_car(resp_car), .resp_cdr(resp_cdr),
    .resp_nil(resp_nil), .resp_err(resp_err), .resp_err_code(resp_err_code),
    .resp_cont(resp_cont));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0] tag; logic [DW-TW-1:0] value; logic [AW-1:0] car, cdr;
    logic nil, err; logic [1:0] code; logic [CW-1:0] cont;
  } rsp_t;
  typedef struct { rsp_t r; int lat; int c; int nrd; logic [AW-1:0] rd0, rd1; } exp_t;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] pipe [L];
  logic          pv [L];
  logic [DW-1:0] noise;
  int            cyc = 0;
  int            n_chk = 0, n_fail = 0;
  int            rr_mode = 0;
  exp_t          sb [$];
  logic [AW-1:0] rd_log [$];

  // Heap RAM: data for a read strobed in cycle c is driven only during cycle c+L.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    noise <= DW'($urandom);
    pipe[0] <= mem[mem_addr];
    pv[0]   <= mem_re;
    for (int i = 1; i < L; i++) begin
      pipe[i] <= pipe[i-1];
      pv[i]   <= pv[i-1];
    end
  end
  assign mem_rdata = pv[L-1] ? pipe[L-1] : noise;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic rsp_t cur();
    rsp_t x;
    x.tag = resp_tag; x.value = resp_value; x.car = resp_car; x.cdr = resp_cdr;
    x.nil = resp_nil; x.err = resp_err; x.code = resp_err_code; x.cont = resp_cont;
    return x;
  endfunction

  // Reference: what the cell at address a means, independent of how it is fetched.
  function automatic exp_t model(input logic [AW-1:0] a, input logic [CW-1:0] ct);
    exp_t e;
    logic [DW-1:0] w;
    e.r = '0; e.r.cont = ct; e.nrd = 0; e.rd0 = a; e.rd1 = a + 1; e.c = cyc;
    if (a == 0) begin
      e.r.nil = 1; e.lat = 1;
    end else begin
      w = mem[a]; e.r.tag = w[DW-1 -: TW]; e.nrd = 1; e.lat = 2 + L;
      if (e.r.tag == 0) e.r.value = w[DW-TW-1:0];
      else if (e.r.tag == 1) begin
        e.r.car = w[AW-1:0];
        if (a == {AW{1'b1}}) e.r.code = 2;
        else begin
          e.r.cdr = mem[a+1][AW-1:0]; e.nrd = 2; e.lat = 3 + 2*L;
        end
      end else e.r.code = 1;
      e.r.err = (e.r.code != 0);
    end
    return e;
  endfunction

  // Monitor: compares on the first valid cycle, checks hold under backpressure, pops on handshake.
  bit   in_resp = 0, hold_v = 0;
  rsp_t hold_r;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_resp = 0; hold_v = 0; rd_log.delete();
    end else begin
      if (mem_re) rd_log.push_back(mem_addr);
      if (hold_v) chk(resp_valid && cur() == hold_r, "hold_stable", 64'(cur()), 64'(hold_r));
      if (resp_valid) begin
        if (!in_resp) begin
          in_resp = 1;
          if (sb.size() == 0) chk(0, "spurious_resp", 64'(cur()), 0);
          else begin
            chk(cur() == sb[0].r, "resp_fields", 64'(cur()), 64'(sb[0].r));
            chk(cyc - sb[0].c == sb[0].lat, "resp_latency", 64'(cyc - sb[0].c), 64'(sb[0].lat));
            chk(rd_log.size() == sb[0].nrd &&
                (sb[0].nrd < 1 || rd_log[0] == sb[0].rd0) &&
                (sb[0].nrd < 2 || rd_log[1] == sb[0].rd1),
                "mem_reads", 64'(rd_log.size()), 64'(sb[0].nrd));
          end
        end
        if (resp_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          in_resp = 0; hold_v = 0; rd_log.delete();
        end else begin
          hold_v = 1; hold_r = cur();
        end
      end
    end
  end

  // resp_ready changes just after posedge so the monitor sees the value the DUT will sample.
  initial forever begin
    @(posedge clk); #1;
    resp_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? ($urandom % 3 != 0) : 1'b0;
  end

  task automatic issue(input logic [AW-1:0] a, input logic [CW-1:0] ct);
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk(0, "req_ready_timeout", 0, 1);
    req_valid = 1; req_addr = a; req_cont = ct;
    sb.push_back(model(a, ct));
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || !req_ready) && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) chk(0, "drain_timeout", 64'(sb.size()), 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    for (int i = 0; i < L; i++) begin pipe[i] = '0; pv[i] = 0; end
    noise = '0;
    repeat (3) @(negedge clk);
    chk(req_ready == 1 && resp_valid == 0 && mem_re == 0, "reset_handshake",
        {req_ready, resp_valid, mem_re}, 3'b100);
    chk(cur() == '0 && mem_addr == 0, "reset_fields", 64'(cur()), 0);
    rst_n = 1;

    // Abort a fetch while waiting on word0; the late read data must be ignored.
    mem[12'h040] = 16'h0123;
    issue(12'h040, 4'h9);
    @(negedge clk);
    rst_n = 0; #1;
    chk(req_ready == 1 && resp_valid == 0, "reset_mid_wait0", {req_ready, resp_valid}, 2'b10);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;

    mem[12'h010] = 16'h002A;
    issue(12'h010, 4'h3); drain();
    mem[12'h020] = 16'h2005; mem[12'h021] = 16'h0007;
    issue(12'h020, 4'h5); drain();
    rr_mode = 2;
    issue(12'h000, 4'hA);
    repeat (5) @(negedge clk);
    chk(resp_valid && resp_nil, "nil_held", {resp_valid, resp_nil}, 2'b11);
    rr_mode = 0; drain();
    mem[12'h030] = 16'hE000;
    issue(12'h030, 4'h1); drain();
    mem[12'hFFF] = 16'h2001; mem[12'h000] = 16'h2222;
    issue(12'hFFF, 4'h7); drain();

    rr_mode = 1;
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] a;
      int r, tg;
      r = $urandom % 10;
      a = (r == 0) ? '0 : (r == 1) ? '1 : AW'($urandom_range(1, (1 << AW) - 2));
      for (int j = 0; j < 2; j++) begin
        r  = $urandom % 8;
        tg = (r < 3) ? 0 : (r < 6) ? 1 : $urandom_range(2, 7);
        mem[AW'(a + j)] = {TW'(tg), (DW-TW)'($urandom)};
      end
      issue(a, CW'($urandom));
      drain();
      repeat ($urandom % 3) @(negedge clk);
    end
    rr_mode = 0;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/heap_cell_fetch.md
Name: heap_cell_fetch

Overview:
- Parametrised heap-cell read sequencer for the Lisp evaluator. Next generation of the single-word memory_read_t request mechanism.
- Accepts a cell address plus a continuation tag, then reads one or two heap words from synchronous RAM with configurable latency.
- Decodes the type tag and returns a number value or car/cdr addresses, with error reporting.
- Sits between the evaluator FSM and heap RAM; the evaluator resumes at the returned continuation.

Parameters:
- ADDR_W, 12, heap address width.
- DATA_W, 16, heap word width; must be ≥ ADDR_W+TAG_W.
- TAG_W, 3, type-tag width, taken from word bits [DATA_W-1 -: TAG_W].
- CONT_W, 4, continuation-state width, passed through untouched.
- MEM_LATENCY, 1, cycles from mem_re sampled to mem_rdata valid; legal range 1..4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle, can accept.
- req_addr  in  ADDR_W  cell address.
- req_cont  in  CONT_W  continuation to return.
- mem_re  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  DATA_W  read data, valid MEM_LATENCY cycles after the mem_re cycle.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts.
- resp_tag  out  TAG_W  decoded tag.
- resp_value  out  DATA_W-TAG_W  word0 payload.
- resp_car  out  ADDR_W  car address (cons only, else 0).
- resp_cdr  out  ADDR_W  cdr address (cons only, else 0).
- resp_nil  out  1  request was NIL (address 0).
- resp_err  out  1  error response.
- resp_err_code  out  2  0 none, 1 bad tag, 2 bounds.
- resp_cont  out  CONT_W  echoed req_cont.

Behaviour:
- Reset values: all outputs 0 except req_ready=1. State IDLE. Reset asserted mid-operation aborts the fetch; any in-flight mem_rdata is ignored after release.
- States: IDLE, RD0, WAIT0, RD1, WAIT1, RESP.
- IDLE:
  - req_ready=1. On req_valid, latch addr and cont.
  - addr==0 → RESP with resp_nil=1, tag=0, no memory access.
  - Otherwise → RD0.
- RD0: mem_re=1, mem_addr=addr for exactly one cycle → WAIT0.
- WAIT0:
  - Count MEM_LATENCY cycles, then sample mem_rdata as word0; tag=word0 top TAG_W bits.
  - TYPE_NUMBER (000): resp_value=word0 low bits → RESP.
  - TYPE_CONS (001): resp_car=word0[ADDR_W-1:0]. If addr == 2^ADDR_W-1 → RESP, err code 2, no wrap read. Else → RD1.
  - Any other tag → RESP, err code 1.
- RD1: mem_re=1, mem_addr=addr+1 → WAIT1.
- WAIT1: after MEM_LATENCY cycles, resp_cdr=word1[ADDR_W-1:0] → RESP.
- RESP:
  - resp_valid=1; all resp_* fields stable until resp_valid && resp_ready, then → IDLE.
  - req_ready=0 in every state except IDLE; one fetch outstanding at most.
- Latency, request accepted at edge k:
  - NIL: resp_valid at cycle k+1.
  - number/error-on-word0: mem_re at cycle k+1, resp_valid at k+2+L.
  - cons: second mem_re at k+2+L, resp_valid at k+3+2L.
- resp_value, resp_car and resp_cdr are zero when they do not apply to the tag.
- mem_re is never asserted twice for the same word; it is never asserted in IDLE or RESP.

Test Plan:
- Reset mid-WAIT0 (L=2): assert rst_n=0 → req_ready=1, resp_valid=0 immediately; next request is served normally.
- Number, L=1: mem[0x010]=16'h002A, request addr 0x010 cont 4'h3 → one mem_re at 0x010; resp_valid at k+3; tag=0, value=0x002A, cont=3, err=0.
- Cons, L=2: mem[0x020]=16'h2005, mem[0x021]=16'h0007 → mem_re at 0x020 then 0x021; resp_valid at k+7; tag=1, car=0x005, cdr=0x007.
- NIL and backpressure: request addr 0 with resp_ready=0 for 5 cycles → resp_nil=1 at k+1, no mem_re; fields held stable; accepted when resp_ready=1.
- Bad tag: mem[0x030]=16'hE000 → err=1, code=1, single mem_re.
- Bounds: mem[0xFFF]=16'h2001 → err=1, code=2, no read at 0x000.
